// File: rtl/bm_dag_sched.sv
// bm_dag_sched
//   Shares one pipelined 2-operand logic unit (AND / OR / XOR / and-not)
//   among four requesters. One request is granted per cycle. Each issued
//   operation is tagged with its requester index, and tagged results come
//   back in issue order after LAT cycles. A result that is offered but not
//   accepted freezes the whole pipeline and the arbiter without losing data.
//
//   Build option:
//     DAG_SCHED_FIXED_PRIO_EN - when defined, the lowest index with req high
//                               wins and there is no round-robin pointer.
//                               When undefined (default), arbitration is
//                               round-robin, starting after the last winner.
//
//   Parameters:
//     BITS - operand/result width
//     LAT  - cycles from the grant edge to result valid (1..4)
//
//   Ports:
//     clock     - rising-edge clock
//     reset     - synchronous active-high reset; clears the pipeline and
//                 the pointer
//     req       - per-requester request, held with its operands until granted
//     op_in     - 2-bit opcode per requester, slice i = op_in[2i+1:2i]
//     a_in      - operand A per requester, slice i = a_in[BITS*i +: BITS]
//     b_in      - operand B per requester, same slicing as a_in
//     gnt       - one-hot combinational grant
//     res_valid - result valid (last pipeline stage)
//     res_ready - consumer accepts the result when high with res_valid
//     res_data  - result data
//     res_id    - index of the requester that issued this result
//     busy      - any pipeline stage holds a valid operation
module bm_dag_sched #(
  parameter int BITS = 2,
  parameter int LAT  = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        req,
  input  logic [7:0]        op_in,
  input  logic [4*BITS-1:0] a_in,
  input  logic [4*BITS-1:0] b_in,
  output logic [3:0]        gnt,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [BITS-1:0]   res_data,
  output logic [1:0]        res_id,
  output logic              busy
);

  logic            stg_valid [LAT];
  logic [BITS-1:0] stg_data  [LAT];
  logic [1:0]      stg_id    [LAT];

  logic            stall;
  logic            any_req;
  logic [1:0]      winner;
  logic [1:0]      op_sel;
  logic [BITS-1:0] a_sel;
  logic [BITS-1:0] b_sel;
  logic [BITS-1:0] op_result;

  // The last stage drives the result port straight from its registers.
  assign res_valid = stg_valid[LAT-1];
  assign res_data  = stg_data[LAT-1];
  assign res_id    = stg_id[LAT-1];

  // An offered result that is not taken freezes everything upstream.
  assign stall = res_valid & ~res_ready;

`ifdef DAG_SCHED_FIXED_PRIO_EN
  // Fixed priority: scanning from the top down leaves the lowest requesting
  // index as the final assignment.
  always_comb begin
    any_req = 1'b0;
    winner  = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        any_req = 1'b1;
        winner  = 2'(i);
      end
    end
  end
`else
  logic [1:0] ptr;
  logic [1:0] idx;

  // Round-robin: the candidate order is ptr+1, ptr+2, ptr+3, ptr. The loop
  // runs from the farthest candidate to the nearest so the nearest requesting
  // one is written last and wins. The 2-bit wrap of ptr+4 yields ptr itself.
  always_comb begin
    any_req = 1'b0;
    winner  = ptr;
    idx     = ptr;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (req[idx]) begin
        any_req = 1'b1;
        winner  = idx;
      end
    end
  end

  // The pointer follows the last winner and holds on bubbles and stalls.
  // Its reset value of 3 gives requester 0 first priority.
  always_ff @(posedge clock) begin
    if (reset) begin
      ptr <= 2'd3;
    end else if (!stall && any_req) begin
      ptr <= winner;
    end
  end
`endif

  // Select the winner's opcode and operands, then evaluate the operation.
  // Opcode 11 is a ^ (a | b), which reduces to ~a & b.
  always_comb begin
    op_sel = op_in[2*winner +: 2];
    a_sel  = a_in[BITS*winner +: BITS];
    b_sel  = b_in[BITS*winner +: BITS];
    case (op_sel)
      2'b00:   op_result = a_sel & b_sel;
      2'b01:   op_result = a_sel | b_sel;
      2'b10:   op_result = a_sel ^ b_sel;
      default: op_result = ~a_sel & b_sel;
    endcase
  end

  // The grant is suppressed during reset and while the pipeline is frozen.
  always_comb begin
    gnt = 4'b0000;
    if (!reset && !stall && any_req) begin
      gnt[winner] = 1'b1;
    end
  end

  // Stage 1 captures the granted result or a bubble. The later stages are a
  // plain delay line, and all stages move together or not at all.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        stg_valid[i] <= 1'b0;
        stg_data[i]  <= '0;
        stg_id[i]    <= 2'd0;
      end
    end else if (!stall) begin
      stg_valid[0] <= any_req;
      stg_data[0]  <= any_req ? op_result : '0;
      stg_id[0]    <= any_req ? winner : 2'd0;
      for (int i = 1; i < LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_data[i]  <= stg_data[i-1];
        stg_id[i]    <= stg_id[i-1];
      end
    end
  end

  // Busy whenever any stage still carries a real operation.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      busy = busy | stg_valid[i];
    end
  end

endmodule
